// File: rtl/sipo_word_assembler_pkg.sv
// Shared definitions for the serial-to-parallel word assembler: output FSM
// state encodings and the default word width.
package sipo_word_assembler_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : sipo_word_assembler_pkg

// File: rtl/sipo_word_assembler_shift_reg.sv
// Shift register and bit counter. It assembles WIDTH serial bits and flags
// the cycle in which the last bit of a word is accepted.
module sipo_shift_reg
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic [WIDTH-1:0] word_next,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;

  // word_next is the register value after this cycle's shift, so the top
  // level can capture a completed word on the same edge that accepts its
  // last bit.
  always_comb begin
    if (MSB_FIRST) begin
      word_next = {sr[WIDTH-2:0], bit_in};
    end else begin
      word_next = {bit_in, sr[WIDTH-1:1]};
    end
  end

  assign word_done = bit_valid && (bit_count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (bit_valid) begin
      sr <= word_next;
      if (word_done) begin
        bit_count <= '0;
      end else begin
        bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

endmodule : sipo_shift_reg

// File: rtl/sipo_word_assembler.sv
// Serial-to-parallel word assembler with a one-entry output holding register,
// a valid/ready output handshake and a sticky overflow flag.
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_count
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("sipo_word_assembler: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] word_next;
  logic             word_done;

  out_state_e state;
  out_state_e state_next;
  logic       load_word;
  logic       set_overflow;

  sipo_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CNT_W)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_count(bit_count),
    .word_next(word_next),
    .word_done(word_done)
  );

  // Handshake: a word transfers on any edge where word_valid && word_ready.
  // word_out is stable while word_valid is high; word_ready is a don't-care
  // when word_valid is low. A completion while a word is pending and not
  // being taken is dropped and recorded in overflow.
  always_comb begin
    state_next   = state;
    load_word    = 1'b0;
    set_overflow = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (word_done) begin
          load_word  = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (word_done) begin
          if (word_ready) begin
            load_word = 1'b1;
          end else begin
            set_overflow = 1'b1;
          end
        end else if (word_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ST_EMPTY;
      word_out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (load_word) begin
        word_out <= word_next;
      end
      if (set_overflow) begin
        overflow <= 1'b1;
      end
    end
  end

  // The valid flag is the FSM state itself, which also serves as the
  // observable state of the output stage.
  assign word_valid = (state == ST_FULL);

endmodule : sipo_word_assembler

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler: an MSB-first and an LSB-first
// instance share the same stimulus; each scenario task checks its own outputs.
module tb_sipo_word_assembler;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          clear;
  logic          word_ready;

  logic [W-1:0]  m_word_out;
  logic          m_word_valid;
  logic          m_overflow;
  logic [CW-1:0] m_bit_count;

  logic [W-1:0]  l_word_out;
  logic          l_word_valid;
  logic          l_overflow;
  logic [CW-1:0] l_bit_count;

  int errors = 0;
  int checks = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .word_out  (m_word_out),
    .word_valid(m_word_valid),
    .word_ready(word_ready),
    .overflow  (m_overflow),
    .bit_count (m_bit_count)
  );

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .word_out  (l_word_out),
    .word_valid(l_word_valid),
    .word_ready(word_ready),
    .overflow  (l_overflow),
    .bit_count (l_bit_count)
  );

  // Advance one clock edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    bit_valid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // Sends the 8 bits of v, v[7] first, on consecutive cycles.
  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      bit_in    = v[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1; tick();
    bit_in = 1'b0; tick();
    bit_in = 1'b1; tick();
    checks++;
    if (m_bit_count !== 3'd3) begin
      errors++; $display("FAIL pre_reset_count: got %0d want 3", m_bit_count);
    end
    // reset mid-word with bit_valid still asserted: rst wins
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bit_valid = 1'b0;
    checks++;
    if (m_bit_count !== 3'd0 || m_word_valid !== 1'b0 || m_overflow !== 1'b0 ||
        m_word_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d valid=%b ovf=%b out=%h want 0 0 0 00",
               m_bit_count, m_word_valid, m_overflow, m_word_out);
    end
    checks++;
    if (l_word_out !== 8'h00 || l_word_valid !== 1'b0 || l_bit_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state_lsb: out=%h valid=%b cnt=%0d want 00 0 0",
               l_word_out, l_word_valid, l_bit_count);
    end
    word_ready = 1'b1;
    send_bits(8'hB4);
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'hB4) begin
      errors++;
      $display("FAIL post_reset_word: valid=%b out=%h want 1 b4", m_word_valid, m_word_out);
    end
    tick();
  endtask

  task automatic test_msb_first();
    do_clear();
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_in    = (i < 2);
      bit_valid = 1'b1;
      tick();
      if (i < 7) begin
        checks++;
        if (m_word_valid !== 1'b0 || m_bit_count !== CW'(i + 1)) begin
          errors++;
          $display("FAIL msb_early_valid: bit %0d valid=%b cnt=%0d want 0 %0d",
                   i, m_word_valid, m_bit_count, i + 1);
        end
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'hC0 || m_bit_count !== 3'd0) begin
      errors++;
      $display("FAIL msb_word: valid=%b out=%h cnt=%0d want 1 c0 0",
               m_word_valid, m_word_out, m_bit_count);
    end
    tick();
    checks++;
    if (m_word_valid !== 1'b0 || m_word_out !== 8'hC0) begin
      errors++;
      $display("FAIL msb_one_cycle: valid=%b out=%h want 0 c0", m_word_valid, m_word_out);
    end
  endtask

  task automatic test_lsb_first();
    do_clear();
    word_ready = 1'b1;
    send_bits(8'hC0);
    checks++;
    if (l_word_valid !== 1'b1 || l_word_out !== 8'h03) begin
      errors++;
      $display("FAIL lsb_word: valid=%b out=%h want 1 03", l_word_valid, l_word_out);
    end
    tick();
    checks++;
    if (l_word_valid !== 1'b0) begin
      errors++; $display("FAIL lsb_consume: valid=%b want 0", l_word_valid);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    word_ready = 1'b0;
    send_bits(8'hA5);
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'hA5 || m_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: valid=%b out=%h ovf=%b want 1 a5 0",
               m_word_valid, m_word_out, m_overflow);
    end
    send_bits(8'h3C);
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'hA5 || m_overflow !== 1'b1 ||
        m_bit_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drop: valid=%b out=%h ovf=%b cnt=%0d want 1 a5 1 0",
               m_word_valid, m_word_out, m_overflow, m_bit_count);
    end
    word_ready = 1'b1;
    tick();
    checks++;
    if (m_word_valid !== 1'b0 || m_overflow !== 1'b1 || m_word_out !== 8'hA5) begin
      errors++;
      $display("FAIL ovf_drain: valid=%b ovf=%b out=%h want 0 1 a5",
               m_word_valid, m_overflow, m_word_out);
    end
    tick();
    tick();
    checks++;
    if (m_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b want 1", m_overflow);
    end
    do_clear();
    checks++;
    if (m_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b want 0", m_overflow);
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    logic [7:0] v2;
    do_clear();
    word_ready = 1'b0;
    send_bits(8'h11);
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'h11) begin
      errors++;
      $display("FAIL b2b_first: valid=%b out=%h want 1 11", m_word_valid, m_word_out);
    end
    gaps = 0;
    v2 = 8'h22;
    for (int i = 7; i >= 0; i--) begin
      bit_in     = v2[i];
      bit_valid  = 1'b1;
      word_ready = (i == 0);
      tick();
      if (m_word_valid !== 1'b1) gaps++;
    end
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_continuous: valid low %0d cycles want 0", gaps);
    end
    checks++;
    if (m_word_out !== 8'h22 || m_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: out=%h ovf=%b want 22 0", m_word_out, m_overflow);
    end
    word_ready = 1'b1;
    tick();
    checks++;
    if (m_word_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: valid=%b want 0", m_word_valid);
    end
  endtask

  task automatic test_gaps_clear();
    do_clear();
    word_ready = 1'b1;
    bit_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bit_valid = (i % 2 == 0);
      tick();
    end
    checks++;
    if (m_bit_count !== 3'd5) begin
      errors++; $display("FAIL gaps_count: got %0d want 5", m_bit_count);
    end
    bit_valid = 1'b0;
    tick();
    checks++;
    if (m_bit_count !== 3'd5) begin
      errors++; $display("FAIL gaps_hold: got %0d want 5", m_bit_count);
    end
    // a bit presented with clear must be ignored
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    clear = 1'b0; bit_valid = 1'b0;
    checks++;
    if (m_bit_count !== 3'd0 || m_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_clear: cnt=%0d valid=%b want 0 0", m_bit_count, m_word_valid);
    end
    send_bits(8'h5A);
    checks++;
    if (m_word_valid !== 1'b1 || m_word_out !== 8'h5A) begin
      errors++;
      $display("FAIL gaps_word: valid=%b out=%h want 1 5a", m_word_valid, m_word_out);
    end
    checks++;
    if (l_word_out !== 8'h5A) begin
      errors++; $display("FAIL gaps_word_lsb: out=%h want 5a", l_word_out);
    end
    tick();
  endtask

  initial begin
    idle();
    word_ready = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overflow();
    test_back_to_back();
    test_gaps_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sipo_word_assembler
